// File: rtl/riscv_bus_pkg.sv
// Shared decode constants for the RISC-V data-port responder: I/O register
// offsets, STATUS bit positions and the address-region type.
package riscv_bus_pkg;

   localparam logic [11:0] LED_OFF    = 12'h000;
   localparam logic [11:0] SW_OFF     = 12'h004;
   localparam logic [11:0] TCOUNT_OFF = 12'h008;
   localparam logic [11:0] TCMP_OFF   = 12'h00C;
   localparam logic [11:0] STATUS_OFF = 12'h010;
   localparam logic [11:0] TXDATA_OFF = 12'h014;

   localparam int ST_FULL     = 0;
   localparam int ST_EMPTY    = 1;
   localparam int ST_TFLAG    = 2;
   localparam int ST_OVF      = 3;
   localparam int ST_CNT_LSB  = 4;
   localparam int CNT_FIELD_W = 4;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_IO,
      REG_NONE
   } addr_region_e;

endpackage

// File: rtl/bus_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. The head is registered (no fall-through),
// and a push that finds the FIFO full without a simultaneous pop sets a sticky overflow.
module bus_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   ready,
   input  logic                   ovf_clr,
   output logic                   full,
   output logic                   empty,
   output logic                   ovf,
   output logic                   valid,
   output logic [WIDTH-1:0]       data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign valid   = !empty;
   assign do_pop  = valid && ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign do_push = push && !rst && (!full || do_pop);
   assign data    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (push && full && !do_pop) ovf <= 1'b1;
         else if (ovf_clr)            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/riscv_data_bus_responder.sv
// Data-port responder for a single-cycle RISC-V core: word RAM plus LED, switch,
// timer and TX-FIFO registers, with a combinational read path back to the core.
module riscv_data_bus_responder
   import riscv_bus_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RAM_BASE  = 32'h0000_1000,
   parameter int              RAM_WORDS = 1024,
   parameter logic [XLEN-1:0] IO_BASE   = 32'h0000_2000,
   parameter int              TX_DEPTH  = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] DataAddress_i,
   input  logic [XLEN-1:0] DataOut_i,
   input  logic            we_i,
   output logic [XLEN-1:0] DataIn_o,
   input  logic [15:0]     switches_i,
   output logic [15:0]     led_o,
   output logic [7:0]      tx_data_o,
   output logic            tx_valid_o,
   input  logic            tx_ready_i
);

   localparam int              IDX_W    = $clog2(RAM_WORDS);
   localparam int              CNT_W    = $clog2(TX_DEPTH) + 1;
   localparam logic [XLEN-1:0] RAM_SPAN = XLEN'(4 * RAM_WORDS);
   localparam logic [XLEN-1:0] IO_SPAN  = XLEN'(4096);

   logic [XLEN-1:0]  addr;
   logic [XLEN-1:0]  ram_off;
   logic [XLEN-1:0]  io_off;
   logic [IDX_W-1:0] ram_idx;
   logic [11:0]      io_sel;
   addr_region_e     region;

   logic [XLEN-1:0]  ram [RAM_WORDS];
   logic [15:0]      led_reg;
   logic [XLEN-1:0]  tcount;
   logic [XLEN-1:0]  tcmp;
   logic             tflag;
   logic [XLEN-1:0]  status;

   logic             wr_ram, wr_io, wr_led, wr_tcount, wr_tcmp, wr_status, wr_txdata;
   logic             tx_full, tx_empty, tx_ovf;
   logic [CNT_W-1:0] tx_count;

   // Byte-lane bits are dropped by masking so every address bit feeds the decode.
   assign addr    = DataAddress_i & ~XLEN'(3);
   assign ram_off = addr - RAM_BASE;
   assign io_off  = addr - IO_BASE;
   assign ram_idx = ram_off[IDX_W+1:2];
   assign io_sel  = io_off[11:0];

   always_comb begin
      region = REG_NONE;
      if (addr >= RAM_BASE && ram_off < RAM_SPAN)    region = REG_RAM;
      else if (addr >= IO_BASE && io_off < IO_SPAN)  region = REG_IO;
   end

   assign wr_ram    = we_i && !rst_i && (region == REG_RAM);
   assign wr_io     = we_i && !rst_i && (region == REG_IO);
   assign wr_led    = wr_io && (io_sel == LED_OFF);
   assign wr_tcount = wr_io && (io_sel == TCOUNT_OFF);
   assign wr_tcmp   = wr_io && (io_sel == TCMP_OFF);
   assign wr_status = wr_io && (io_sel == STATUS_OFF);
   assign wr_txdata = wr_io && (io_sel == TXDATA_OFF);

   always_ff @(posedge clk_i) begin
      if (wr_ram) ram[ram_idx] <= DataOut_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         led_reg <= '0;
         tcount  <= '0;
         tcmp    <= '0;
         tflag   <= 1'b0;
      end else begin
         if (wr_led) led_reg <= DataOut_i[15:0];
         if (wr_tcount) tcount <= DataOut_i;
         else           tcount <= tcount + XLEN'(1);
         if (wr_tcmp) tcmp <= DataOut_i;
         if (tcount == tcmp)                         tflag <= 1'b1;
         else if (wr_status && DataOut_i[ST_TFLAG])  tflag <= 1'b0;
      end
   end

   assign led_o = led_reg;

   bus_tx_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (wr_txdata),
      .push_data (DataOut_i[7:0]),
      .ready     (tx_ready_i),
      .ovf_clr   (wr_status && DataOut_i[ST_OVF]),
      .full      (tx_full),
      .empty     (tx_empty),
      .ovf       (tx_ovf),
      .valid     (tx_valid_o),
      .data      (tx_data_o),
      .count     (tx_count)
   );

   always_comb begin
      status                                  = '0;
      status[ST_FULL]                         = tx_full;
      status[ST_EMPTY]                        = tx_empty;
      status[ST_TFLAG]                        = tflag;
      status[ST_OVF]                          = tx_ovf;
      status[ST_CNT_LSB +: CNT_FIELD_W]       = CNT_FIELD_W'(tx_count);
   end

   always_comb begin
      DataIn_o = '0;
      unique case (region)
         REG_RAM: DataIn_o = ram[ram_idx];
         REG_IO: begin
            unique case (io_sel)
               LED_OFF:    DataIn_o = XLEN'(led_reg);
               SW_OFF:     DataIn_o = XLEN'(switches_i);
               TCOUNT_OFF: DataIn_o = tcount;
               TCMP_OFF:   DataIn_o = tcmp;
               STATUS_OFF: DataIn_o = status;
               default:    DataIn_o = '0;
            endcase
         end
         default: DataIn_o = '0;
      endcase
   end

endmodule

// File: tb/tb_riscv_data_bus_responder.sv
// Directed checks plus randomized bus traffic compared every cycle against a
// memory-map level reference model (associative RAM, byte queue, plain counters).
module tb_riscv_data_bus_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] dout;
   logic        we;
   logic [31:0] rdata;
   logic [15:0] sw;
   logic [15:0] led;
   logic [7:0]  txd;
   logic        txv;
   logic        ready;

   always #5 clk = ~clk;

   riscv_data_bus_responder dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .DataAddress_i (addr),
      .DataOut_i     (dout),
      .we_i          (we),
      .DataIn_o      (rdata),
      .switches_i    (sw),
      .led_o         (led),
      .tx_data_o     (txd),
      .tx_valid_o    (txv),
      .tx_ready_i    (ready)
   );

   int n_chk = 0;
   int n_bad = 0;
   bit model_on = 1'b0;

   logic [31:0] m_ram [logic [31:0]];
   logic [15:0] m_led;
   logic [31:0] m_tcount;
   logic [31:0] m_tcmp;
   logic        m_tflag;
   logic        m_ovf;
   logic [7:0]  q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_status();
      return {24'd0, 4'(q.size()), m_ovf, m_tflag, q.size() == 0, q.size() == 4};
   endfunction

   // Returns 0 when the expected value is unknown (never-written RAM word).
   function automatic bit m_read(input logic [31:0] a_in, output logic [31:0] v);
      logic [31:0] a;
      a = a_in & ~32'h3;
      v = 32'h0;
      if (a >= 32'h1000 && a < 32'h2000) begin
         if (!m_ram.exists(a)) return 1'b0;
         v = m_ram[a];
         return 1'b1;
      end
      case (a)
         32'h2000: v = {16'h0, m_led};
         32'h2004: v = {16'h0, sw};
         32'h2008: v = m_tcount;
         32'h200C: v = m_tcmp;
         32'h2010: v = m_status();
         default:  v = 32'h0;
      endcase
      return 1'b1;
   endfunction

   task automatic drive(input bit r, input logic [31:0] a, input logic [31:0] d,
                        input bit w, input bit rdy);
      @(negedge clk);
      rst = r; addr = a; dout = d; we = w; ready = rdy;
      #1;
      if (model_on) begin : mc
         logic [31:0] e;
         if (m_read(a, e)) chk("rdata", rdata, e);
         chk("led_o", {16'h0, led}, {16'h0, m_led});
         chk("tx_valid", {31'h0, txv}, (q.size() > 0) ? 32'h1 : 32'h0);
         chk("tx_data", {24'h0, txd}, (q.size() > 0) ? {24'h0, q[0]} : 32'h0);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      if (rst) begin
         m_led = '0; m_tcount = '0; m_tcmp = '0; m_tflag = 1'b0; m_ovf = 1'b0;
         q.delete();
         model_on = 1'b1;
      end else begin : upd
         logic [31:0] a;
         bit pop, set_t, push, clr_t, clr_o, was_full;
         a        = addr & ~32'h3;
         pop      = (q.size() > 0) && ready;
         set_t    = (m_tcount == m_tcmp);
         was_full = (q.size() == 4);
         push     = we && (a == 32'h2014);
         clr_t    = we && (a == 32'h2010) && dout[2];
         clr_o    = we && (a == 32'h2010) && dout[3];
         if (we && a >= 32'h1000 && a < 32'h2000) m_ram[a] = dout;
         if (we && a == 32'h2000) m_led = dout[15:0];
         if (we && a == 32'h200C) m_tcmp = dout;
         m_tcount = (we && a == 32'h2008) ? dout : m_tcount + 32'd1;
         if (pop) void'(q.pop_front());
         if (push && (!was_full || pop)) q.push_back(dout[7:0]);
         if (push && was_full && !pop) m_ovf = 1'b1;
         else if (clr_o)               m_ovf = 1'b0;
         if (set_t)      m_tflag = 1'b1;
         else if (clr_t) m_tflag = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; addr = '0; dout = '0; we = 1'b0; ready = 1'b0; sw = 16'h1234;

      drive(1, 0, 0, 0, 0); adv();
      drive(1, 0, 0, 0, 0); adv();

      drive(0, 32'h2010, 0, 0, 0);
      chk("rst_status", rdata, 32'h2);
      chk("rst_led", {16'h0, led}, 32'h0);
      chk("rst_txv", {31'h0, txv}, 32'h0);
      adv();
      drive(0, 32'h2000, 0, 0, 0); chk("rst_ledreg", rdata, 32'h0); adv();

      drive(0, 32'h1004, 32'hDEADBEEF, 1, 0); adv();
      drive(0, 32'h1004, 0, 0, 0); chk("ram_rd", rdata, 32'hDEADBEEF); adv();
      drive(0, 32'h0800, 0, 0, 0); chk("unmap_rd", rdata, 32'h0); adv();
      drive(0, 32'h0800, 32'h55, 1, 0); adv();
      drive(0, 32'h0800, 0, 0, 0); chk("unmap_wr", rdata, 32'h0); adv();

      drive(0, 32'h2000, 32'h0001A5A5, 1, 0); adv();
      drive(0, 32'h2004, 0, 0, 0);
      chk("led_set", {16'h0, led}, 32'hA5A5);
      chk("sw_rd", rdata, 32'h1234);
      adv();

      drive(0, 32'h2008, 32'd1000, 1, 0); adv();
      drive(0, 32'h200C, 32'd10, 1, 0); adv();
      drive(0, 32'h2010, 32'h4, 1, 0); adv();
      drive(0, 32'h2008, 32'd0, 1, 0); adv();
      for (int k = 0; k < 13; k++) begin
         drive(0, 32'h2010, 0, 0, 0);
         chk("tflag_timing", {31'h0, rdata[2]}, (k >= 11) ? 32'h1 : 32'h0);
         adv();
      end
      drive(0, 32'h2010, 32'h4, 1, 0); adv();
      drive(0, 32'h2010, 0, 0, 0); chk("tflag_clr", {31'h0, rdata[2]}, 32'h0); adv();

      for (int i = 0; i < 5; i++) begin
         drive(0, 32'h2014, 32'h41 + i, 1, 0); adv();
      end
      drive(0, 32'h2010, 0, 0, 0); chk("fifo_full_st", rdata, 32'h49); adv();
      for (int i = 0; i < 4; i++) begin
         drive(0, 32'h0800, 0, 0, 1);
         chk("drain_v", {31'h0, txv}, 32'h1);
         chk("drain_d", {24'h0, txd}, 32'h41 + i);
         adv();
      end
      drive(0, 32'h0800, 0, 0, 1); chk("drain_end", {31'h0, txv}, 32'h0); adv();
      drive(0, 32'h2010, 32'h8, 1, 0); adv();
      drive(0, 32'h2010, 0, 0, 0); chk("ovf_clr", rdata, 32'h2); adv();

      drive(0, 32'h2014, 32'h61, 1, 0); adv();
      drive(0, 32'h2014, 32'h62, 1, 0); adv();
      drive(1, 32'h2000, 32'hFFFF, 1, 0); adv();
      drive(0, 32'h2010, 0, 0, 0);
      chk("mid_rst_status", rdata, 32'h2);
      chk("mid_rst_led", {16'h0, led}, 32'h0);
      chk("mid_rst_txv", {31'h0, txv}, 32'h0);
      adv();
      drive(0, 32'h2008, 0, 0, 0); chk("mid_rst_tcount", rdata, 32'h1); adv();

      for (int k = 0; k < 8; k++) begin
         drive(0, 32'h1000 + 4 * k, $urandom, 1, 0); adv();
      end
      drive(0, 32'h1FFC, $urandom, 1, 0); adv();

      for (int n = 0; n < 3000; n++) begin : rnd
         logic [31:0] a, d;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 4) begin
            a = ($urandom_range(0, 8) == 8) ? 32'h1FFC : 32'h1000 + 4 * $urandom_range(0, 7);
         end else if (sel < 8) begin
            a = 32'h2000 + 4 * $urandom_range(0, 5);
         end else begin
            case ($urandom_range(0, 3))
               0:       a = 32'h0800;
               1:       a = 32'h3000;
               2:       a = 32'h2018;
               default: a = 32'h0FFC;
            endcase
         end
         a = a | 32'($urandom_range(0, 3));
         d = $urandom;
         if ((a & ~32'h3) == 32'h2008 && $urandom_range(0, 1) == 1)
            d = m_tcmp - 32'($urandom_range(0, 3));
         sw = 16'($urandom);
         drive($urandom_range(0, 99) == 0, a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         adv();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
